i2c_rxff: RTL and testbench

Receive FIFO for the I2C controller, sitting between the I2C byte receive engine (write side) and the APB register interface (read side). It buffers received bytes in a single `pclk` domain and presents the head byte combinationally for the APB data-register read at 0x2C. It reports not-empty, full, level and a sticky overflow flag to the status and interrupt logic.

---
 rtl/i2c_rxff.sv | 78 +++++++
 tb/tb_i2c_rxff.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_rxff.sv
// rtl/i2c_rxff.sv - I2C receive FIFO between the byte receive engine and the APB data register.
// Optional synchronous flush port rx_flush is built in when I2C_RXFF_FLUSH_EN is defined.
module i2c_rxff #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          pclk,
  input  logic          prst_n,
  input  logic          rx_wr,
  input  logic [DW-1:0] rx_data,
  input  logic          apb_rxff_rd,
`ifdef I2C_RXFF_FLUSH_EN
  input  logic          rx_flush,
`endif
  output logic [DW-1:0] rxff_data,
  output logic          rxff_rxne,
  output logic          rxff_full,
  output logic [AW:0]   rxff_level,
  output logic          rxff_ov
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          wr_ok;
  logic          pop_ok;
  logic          flush;

`ifdef I2C_RXFF_FLUSH_EN
  assign flush = rx_flush;
`else
  assign flush = 1'b0;
`endif

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign pop_ok = apb_rxff_rd && (cnt != '0);
  assign wr_ok  = rx_wr && ((cnt != FULL_CNT) || pop_ok);

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      rxff_ov <= 1'b0;
    end else if (flush) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      rxff_ov <= 1'b0;
    end else begin
      if (wr_ok)
        wp <= wp + 1'b1;
      if (pop_ok)
        rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop_ok};
      // Overflow needs the absence of a pop, so set and clear never collide.
      if (rx_wr && !wr_ok)
        rxff_ov <= 1'b1;
      else if (pop_ok)
        rxff_ov <= 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (wr_ok && !flush)
      mem[wp] <= rx_data;
  end

  assign rxff_rxne  = (cnt != '0);
  assign rxff_full  = (cnt == FULL_CNT);
  assign rxff_level = cnt;
  assign rxff_data  = rxff_rxne ? mem[rp] : '0;

endmodule

// File: tb/tb_i2c_rxff.sv
// tb/tb_i2c_rxff.sv - self-checking bench for i2c_rxff with a queue-based scoreboard.
// Exercises the flush path only when I2C_RXFF_FLUSH_EN is defined.
module tb_i2c_rxff;

  logic       pclk;
  logic       prst_n;
  logic       rx_wr;
  logic [7:0] rx_data;
  logic       apb_rxff_rd;
  logic       rx_flush;
  logic [7:0] rxff_data;
  logic       rxff_rxne;
  logic       rxff_full;
  logic [3:0] rxff_level;
  logic       rxff_ov;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] exp_q[$];
  logic       m_ov;

  i2c_rxff #(.AW(3), .DW(8)) dut (
    .pclk        (pclk),
    .prst_n      (prst_n),
    .rx_wr       (rx_wr),
    .rx_data     (rx_data),
    .apb_rxff_rd (apb_rxff_rd),
`ifdef I2C_RXFF_FLUSH_EN
    .rx_flush    (rx_flush),
`endif
    .rxff_data   (rxff_data),
    .rxff_rxne   (rxff_rxne),
    .rxff_full   (rxff_full),
    .rxff_level  (rxff_level),
    .rxff_ov     (rxff_ov)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    chk({tag, "_level"}, {28'd0, rxff_level}, exp_q.size());
    chk({tag, "_rxne"},  {31'd0, rxff_rxne}, {31'd0, exp_q.size() != 0});
    chk({tag, "_full"},  {31'd0, rxff_full}, {31'd0, exp_q.size() == 8});
    chk({tag, "_ov"},    {31'd0, rxff_ov}, {31'd0, m_ov});
    chk({tag, "_head"},  {24'd0, rxff_data}, {24'd0, head});
  endtask

  // One clock cycle of stimulus; called at posedge+1, samples at the next posedge+1.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic fl);
    logic pop;
    logic was_full;
    rx_wr       = wr;
    rx_data     = d;
    apb_rxff_rd = rd;
    rx_flush    = fl;
    #2;
    if (rd && exp_q.size() != 0)
      chk("rd_data", {24'd0, rxff_data}, {24'd0, exp_q[0]});
    if (fl) begin
      exp_q.delete();
      m_ov = 1'b0;
    end else begin
      pop      = rd && (exp_q.size() != 0);
      was_full = (exp_q.size() == 8);
      if (pop) begin
        void'(exp_q.pop_front());
        m_ov = 1'b0;
      end
      if (wr && (!was_full || pop))
        exp_q.push_back(d);
      else if (wr)
        m_ov = 1'b1;
    end
    @(posedge pclk);
    #1;
    rx_wr       = 1'b0;
    apb_rxff_rd = 1'b0;
    rx_flush    = 1'b0;
    check_state("step");
  endtask

  initial begin
    prst_n      = 1'b0;
    rx_wr       = 1'b0;
    rx_data     = 8'h00;
    apb_rxff_rd = 1'b0;
    rx_flush    = 1'b0;
    m_ov        = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    prst_n = 1'b1;
    @(posedge pclk);
    #1;
    chk("rst_level", {28'd0, rxff_level}, 32'd0);
    chk("rst_rxne",  {31'd0, rxff_rxne}, 32'd0);
    chk("rst_full",  {31'd0, rxff_full}, 32'd0);
    chk("rst_ov",    {31'd0, rxff_ov}, 32'd0);
    chk("rst_data",  {24'd0, rxff_data}, 32'd0);

    step(1, 8'hA1, 0, 0);
    step(1, 8'hB2, 0, 0);
    step(1, 8'hC3, 0, 0);
    chk("abc_level3", {28'd0, rxff_level}, 32'd3);
    chk("abc_head", {24'd0, rxff_data}, 32'hA1);
    step(0, 8'h00, 1, 0);
    chk("abc_level2", {28'd0, rxff_level}, 32'd2);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("abc_empty_pop", {28'd0, rxff_level}, 32'd0);

    for (int i = 0; i < 8; i++)
      step(1, 8'h10 + 8'(i), 0, 0);
    chk("fill_full", {31'd0, rxff_full}, 32'd1);
    step(1, 8'h99, 0, 0);
    chk("ov_set", {31'd0, rxff_ov}, 32'd1);
    chk("ov_head", {24'd0, rxff_data}, 32'h10);
    step(0, 8'h00, 1, 0);
    chk("ov_clr", {31'd0, rxff_ov}, 32'd0);
    step(1, 8'h17, 0, 0);

    step(1, 8'h55, 1, 0);
    chk("fullrw_level", {28'd0, rxff_level}, 32'd8);
    chk("fullrw_ov", {31'd0, rxff_ov}, 32'd0);
    for (int i = 0; i < 8; i++)
      step(0, 8'h00, 1, 0);

    step(1, 8'h3C, 1, 0);
    chk("emptyrw_level", {28'd0, rxff_level}, 32'd1);
    chk("emptyrw_data", {24'd0, rxff_data}, 32'h3C);
    step(0, 8'h00, 1, 0);

    for (int i = 0; i < 20; i++) begin
      step(1, 8'($urandom), 0, 0);
      step(0, 8'h00, 1, 0);
    end

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45), 0);

    while (exp_q.size() < 3)
      step(1, 8'($urandom), 0, 0);
    #2;
    prst_n = 1'b0;
    #1;
    exp_q.delete();
    m_ov = 1'b0;
    chk("async_rst_level", {28'd0, rxff_level}, 32'd0);
    chk("async_rst_data", {24'd0, rxff_data}, 32'd0);
    @(posedge pclk);
    #1;
    prst_n = 1'b1;
    check_state("after_rst");

`ifdef I2C_RXFF_FLUSH_EN
    for (int i = 0; i < 8; i++)
      step(1, 8'h60 + 8'(i), 0, 0);
    step(1, 8'hEE, 0, 0);
    chk("fl_ov_pre", {31'd0, rxff_ov}, 32'd1);
    step(1, 8'h77, 1, 1);
    chk("fl_level", {28'd0, rxff_level}, 32'd0);
    chk("fl_ov", {31'd0, rxff_ov}, 32'd0);
    chk("fl_rxne", {31'd0, rxff_rxne}, 32'd0);
    step(1, 8'h42, 0, 0);
    chk("fl_after", {24'd0, rxff_data}, 32'h42);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
